// File: rtl/led_pkg.sv
// Shared defaults for the LED scan timer: counter sizing, digit count,
// blink cadence and the anode drive polarity.
package led_pkg;
    localparam int   DEF_CW           = 17;
    localparam int   DEF_NDIG         = 4;
    localparam int   DEF_DIV_RST      = (2 ** DEF_CW) - 1;
    localparam int   DEF_BLINK_FRAMES = 64;
    // Anodes are driven low to light a digit.
    localparam logic ANODE_ON         = 1'b0;
endpackage

// File: rtl/led_tick_div.sv
// Programmable refresh divider: free-running counter that wraps at div_act,
// with a pending-divisor register so a new divisor only takes effect at a wrap.
module led_tick_div
    import led_pkg::*;
#(
    parameter int             CW      = DEF_CW,
    parameter logic [CW-1:0]  DIV_RST = {CW{1'b1}}
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          ce,
    input  logic [CW-1:0] div,
    input  logic          div_ld,
    output logic          wrap,
    output logic          tick,
    output logic          ld_pend
);
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] div_act_reg;
    logic [CW-1:0] div_pend_reg;
    logic          ld_pend_reg;
    logic          tick_reg;

    assign wrap    = ce && (cnt_reg == div_act_reg);
    // The tick flag is held across disabled cycles and only shown while enabled.
    assign tick    = tick_reg & ce;
    assign ld_pend = ld_pend_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg      <= '0;
            div_act_reg  <= DIV_RST;
            div_pend_reg <= '0;
            ld_pend_reg  <= 1'b0;
            tick_reg     <= 1'b0;
        end else begin
            if (ce) begin
                tick_reg <= wrap;
                cnt_reg  <= wrap ? '0 : cnt_reg + CW'(1);
            end
            // Load strobes are captured regardless of ce so a one-cycle request is never lost.
            if (div_ld && wrap) begin
                div_act_reg <= div;
                ld_pend_reg <= 1'b0;
            end else if (div_ld) begin
                div_pend_reg <= div;
                ld_pend_reg  <= 1'b1;
            end else if (wrap && ld_pend_reg) begin
                div_act_reg <= div_pend_reg;
                ld_pend_reg <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/led_scan_timer.sv
// Multiplexed LED display scan timer: refresh tick, digit/anode scan, frame
// pulse and optional blink cadence (enabled by defining LED_BLINK_EN).
module led_scan_timer
    import led_pkg::*;
#(
    parameter int            CW           = DEF_CW,
    parameter int            NDIG         = DEF_NDIG,
    parameter logic [CW-1:0] DIV_RST      = {CW{1'b1}},
    parameter int            BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                    CLK_100MHz,
    input  logic                    RST,
    input  logic                    i_ce,
    input  logic [CW-1:0]           i_div,
    input  logic                    i_div_ld,
    input  logic                    i_blink_en,
    output logic                    o_ld_pend,
    output logic                    o_tick,
    output logic                    o_clk_led,
    output logic [$clog2(NDIG)-1:0] o_digit_sel,
    output logic [NDIG-1:0]         o_an,
    output logic                    o_frame,
    output logic                    o_blank
);
    localparam int DW = $clog2(NDIG);

    logic            wrap;
    logic [DW-1:0]   digit_reg;
    logic [DW-1:0]   digit_next;
    logic [NDIG-1:0] an_reg;
    logic [NDIG-1:0] an_next;
    logic [NDIG-1:0] an_rst;
    logic            led_reg;
    logic            frame_reg;
    logic            frame_evt;

    led_tick_div #(
        .CW      (CW),
        .DIV_RST (DIV_RST)
    ) u_tick_div (
        .clk     (CLK_100MHz),
        .srst    (RST),
        .ce      (i_ce),
        .div     (i_div),
        .div_ld  (i_div_ld),
        .wrap    (wrap),
        .tick    (o_tick),
        .ld_pend (o_ld_pend)
    );

    always_comb begin
        digit_next = (digit_reg == DW'(NDIG - 1)) ? '0 : digit_reg + DW'(1);
    end

    assign frame_evt = wrap && (digit_next == '0);

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_an
            assign an_next[gi] = (digit_next == DW'(gi)) ? ANODE_ON : ~ANODE_ON;
            assign an_rst[gi]  = (gi == 0) ? ANODE_ON : ~ANODE_ON;
        end
    endgenerate

    always_ff @(posedge CLK_100MHz) begin
        if (RST) begin
            digit_reg <= '0;
            an_reg    <= an_rst;
            led_reg   <= 1'b0;
            frame_reg <= 1'b0;
        end else if (wrap) begin
            digit_reg <= digit_next;
            an_reg    <= an_next;
            led_reg   <= ~led_reg;
            frame_reg <= frame_evt;
        end else if (i_ce) begin
            frame_reg <= 1'b0;
        end
    end

    assign o_digit_sel = digit_reg;
    assign o_an        = an_reg;
    assign o_clk_led   = led_reg;
    assign o_frame     = frame_reg & i_ce;

`ifdef LED_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [FW-1:0] fcnt_reg;
    logic          blank_reg;

    always_ff @(posedge CLK_100MHz) begin
        if (RST || !i_blink_en) begin
            fcnt_reg  <= '0;
            blank_reg <= 1'b0;
        end else if (frame_evt) begin
            if (fcnt_reg == FW'(BLINK_FRAMES - 1)) begin
                fcnt_reg  <= '0;
                blank_reg <= ~blank_reg;
            end else begin
                fcnt_reg <= fcnt_reg + FW'(1);
            end
        end
    end

    assign o_blank = blank_reg;
`else
    logic blink_unused;
    assign blink_unused = i_blink_en;
    assign o_blank      = 1'b0;
`endif
endmodule

// File: tb/tb_led_scan_timer.sv
// Randomized self-checking bench for led_scan_timer against a tick-count based
// reference model, plus directed scenarios with hand-computed expectations.
module tb_led_scan_timer;
    localparam int CW   = 4;
    localparam int NDIG = 4;
    localparam int BF   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst      = 1'b1;
    logic          ce       = 1'b0;
    logic          div_ld   = 1'b0;
    logic          blink_en = 1'b0;
    logic [CW-1:0] div      = '0;

    logic          o_ld_pend, o_tick, o_clk_led, o_frame, o_blank;
    logic [1:0]    o_digit_sel;
    logic [3:0]    o_an;

    led_scan_timer #(
        .CW           (CW),
        .NDIG         (NDIG),
        .DIV_RST      (4'd3),
        .BLINK_FRAMES (BF)
    ) dut (
        .CLK_100MHz  (clk),
        .RST         (rst),
        .i_ce        (ce),
        .i_div       (div),
        .i_div_ld    (div_ld),
        .i_blink_en  (blink_en),
        .o_ld_pend   (o_ld_pend),
        .o_tick      (o_tick),
        .o_clk_led   (o_clk_led),
        .o_digit_sel (o_digit_sel),
        .o_an        (o_an),
        .o_frame     (o_frame),
        .o_blank     (o_blank)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input int got, input int want);
        vec_cnt++;
        if (got != want) begin
            err_cnt++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: enabled-cycle phase within the period, total ticks since
    // reset, and frames seen since blinking was last enabled.
    int m_phase, m_div, m_pval, m_ticks, m_frames;
    bit m_pend, m_tick, m_frame, m_term, m_fevt;
    bit m_valid = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_div = 3; m_pval = 0; m_ticks = 0; m_frames = 0;
            m_pend = 0; m_tick = 0; m_frame = 0;
            m_valid = 1'b1;
        end else begin
            m_term = ce && (m_phase == m_div);
            m_fevt = m_term && (((m_ticks + 1) % NDIG) == 0);
            if (ce) begin
                m_tick  = m_term;
                m_frame = m_fevt;
            end
            if (m_term) begin
                m_phase = 0;
                m_ticks++;
            end else if (ce) begin
                m_phase++;
            end
            if (div_ld && m_term) begin
                m_div = int'(div); m_pend = 0;
            end else if (div_ld) begin
                m_pval = int'(div); m_pend = 1;
            end else if (m_term && m_pend) begin
                m_div = m_pval; m_pend = 0;
            end
            if (!blink_en) m_frames = 0;
            else if (m_fevt) m_frames++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("tick",    int'(o_tick),      int'(m_tick && ce));
            check("frame",   int'(o_frame),     int'(m_frame && ce));
            check("clk_led", int'(o_clk_led),   m_ticks % 2);
            check("digit",   int'(o_digit_sel), m_ticks % NDIG);
            check("an",      int'(o_an),        (~(1 << (m_ticks % NDIG))) & 15);
            check("ld_pend", int'(o_ld_pend),   int'(m_pend));
`ifdef LED_BLINK_EN
            check("blank",   int'(o_blank),     (m_frames / BF) % 2);
`else
            check("blank",   int'(o_blank),     0);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench at the start of cycle 1 after release.
    task automatic do_reset();
        rst = 1'b1; ce = 1'b0; div_ld = 1'b0;
        cyc();
        cyc();
        #1;
        check("lit_rst_an",    int'(o_an),        14);
        check("lit_rst_tick",  int'(o_tick),      0);
        check("lit_rst_led",   int'(o_clk_led),   0);
        check("lit_rst_digit", int'(o_digit_sel), 0);
        check("lit_rst_pend",  int'(o_ld_pend),   0);
        rst = 1'b0;
    endtask

    int          tick_cyc[$];
    logic [3:0]  an_q[$];
    logic        fr_q[$];
    logic [3:0]  exp_an [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    int          n;
    int          chg[$];
    logic        prev_blank;

    initial begin
        // Power-up sequence: first tick in cycle 5, then every 4 cycles.
        blink_en = 1'b1;
        do_reset();
        ce = 1'b1;
        for (int c = 2; c <= 17; c++) begin
            cyc(); #1;
            if (o_tick) begin
                tick_cyc.push_back(c);
                an_q.push_back(o_an);
                fr_q.push_back(o_frame);
            end
        end
        check("lit_tick_count", tick_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < tick_cyc.size()) begin
                check("lit_tick_cycle", tick_cyc[i], 5 + 4 * i);
                check("lit_an_seq",     int'(an_q[i]), int'(exp_an[i]));
                check("lit_frame_seq",  int'(fr_q[i]), (i == 3) ? 1 : 0);
            end
        end

        // Alternating enable: period doubles to 8 cycles.
        for (int i = 0; i < 16; i++) begin
            ce = (i % 2 == 0); cyc();
        end
        n = 0;
        for (int i = 0; i < 32; i++) begin
            ce = (i % 2 == 0); cyc(); #1;
            if (o_tick) n++;
        end
        check("lit_alt_ticks", n, 4);

        // Divisor load mid-period: pending until wrap, then tick every cycle.
        do_reset();
        ce = 1'b1;
        cyc();
        div_ld = 1'b1; div = 4'd0;
        cyc();
        div_ld = 1'b0; #1;
        check("lit_pend_c3", int'(o_ld_pend), 1);
        cyc(); #1;
        check("lit_pend_c4", int'(o_ld_pend), 1);
        cyc(); #1;
        check("lit_pend_c5", int'(o_ld_pend), 0);
        check("lit_tick_c5", int'(o_tick), 1);
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            check("lit_tick_div0", int'(o_tick), 1);
        end

        // Load coincident with the terminal count applies directly.
        do_reset();
        ce = 1'b1;
        cyc(); cyc(); cyc();
        div_ld = 1'b1; div = 4'd1;
        cyc();
        div_ld = 1'b0; #1;
        check("lit_direct_pend", int'(o_ld_pend), 0);
        check("lit_direct_tick", int'(o_tick), 1);
        for (int c = 6; c <= 9; c++) begin
            cyc(); #1;
            check("lit_direct_pend", int'(o_ld_pend), 0);
            check("lit_div1_tick", int'(o_tick), c % 2);
        end

        // Reset mid-scan at digit 2, then the reset divisor is back in force.
        do_reset();
        ce = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        #1;
        check("lit_pre_digit", int'(o_digit_sel), 2);
        rst = 1'b1;
        cyc(); #1;
        check("lit_mid_an",    int'(o_an), 14);
        check("lit_mid_led",   int'(o_clk_led), 0);
        check("lit_mid_digit", int'(o_digit_sel), 0);
        rst = 1'b0;
        cyc(); cyc(); cyc(); #1;
        check("lit_mid_c4_tick", int'(o_tick), 0);
        cyc(); #1;
        check("lit_mid_c5_tick", int'(o_tick), 1);

`ifdef LED_BLINK_EN
        // Blink cadence: toggles every 32 cycles, cleared when disabled.
        do_reset();
        ce = 1'b1; blink_en = 1'b1;
        prev_blank = o_blank;
        for (int c = 2; c <= 100; c++) begin
            cyc(); #1;
            if (o_blank != prev_blank) chg.push_back(c);
            prev_blank = o_blank;
        end
        check("lit_blink_changes", chg.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < chg.size()) check("lit_blink_cycle", chg[i], 33 + 32 * i);
        end
        check("lit_blink_on", int'(o_blank), 1);
        blink_en = 1'b0;
        cyc(); #1;
        check("lit_blink_off", int'(o_blank), 0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            ce       = ($urandom_range(0, 3) != 0);
            div_ld   = ($urandom_range(0, 19) == 0);
            div      = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 15))
                                                   : CW'($urandom_range(0, 3));
            blink_en = ($urandom_range(0, 49) != 0);
            cyc();
        end

        #20;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/led_scan_timer.md
LED_SCAN_TIMER -- requirements
Module: led_scan_timer

Interface
REQ-001 SHALL provide parameter CW, default 17: divide-counter width in bits.
REQ-002 SHALL provide parameter NDIG, default 4: number of multiplexed display digits (≥2).
REQ-003 SHALL provide parameter DIV_RST, default 2**CW-1: divisor loaded at reset.
REQ-004 SHALL provide parameter BLINK_FRAMES, default 64: frames per blink half-period.
REQ-005 CLK_100MHz  in  1  sole clock, all logic on rising edge.
REQ-006 RST  in  1  reset; synchronous, active-high.
REQ-007 i_ce  in  1  clock enable; counting advances only when high.
REQ-008 i_div  in  CW  new divisor value.
REQ-009 i_div_ld  in  1  one-cycle strobe requesting divisor load.
REQ-010 i_blink_en  in  1  enables display blanking cadence.
REQ-011 o_ld_pend  out  1  divisor load accepted, not yet applied.
REQ-012 o_tick  out  1  one-cycle refresh pulse.
REQ-013 o_clk_led  out  1  square wave, toggles per tick.
REQ-014 o_digit_sel  out  clog2(NDIG)  active digit index.
REQ-015 o_an  out  NDIG  active-low one-hot anode select.
REQ-016 o_frame  out  1  one-cycle pulse on digit wrap.
REQ-017 o_blank  out  1  display blank request.

Function
REQ-018 Counter cnt SHALL increment on each cycle with i_ce=1; with i_ce=0 all state SHALL hold and o_tick/o_frame SHALL be 0.
REQ-019 Terminal count: cnt==div_act with i_ce=1 -> cnt<=0; o_tick SHALL be high for exactly the following cycle (1-cycle latency); tick period = (div_act+1) enabled cycles; div_act=0 gives a tick every enabled cycle.
REQ-020 o_clk_led SHALL toggle on the same edge that asserts o_tick.
REQ-021 o_digit_sel SHALL advance by 1 with each tick, wrapping NDIG-1 -> 0; o_an SHALL equal ~(1<<o_digit_sel), registered with o_digit_sel.
REQ-022 o_frame SHALL assert coincident with the tick that wraps o_digit_sel to 0.
REQ-023 i_div_ld=1 SHALL capture i_div into div_pend and set o_ld_pend the next cycle; div_act<=div_pend at the next terminal count, o_ld_pend cleared there.
REQ-024 i_div_ld coincident with a terminal count SHALL apply i_div at that wrap directly; o_ld_pend stays 0.
REQ-025 A second i_div_ld while o_ld_pend=1 SHALL overwrite div_pend (last write wins).
REQ-026 A divisor change SHALL never truncate the current period; cnt is not compared to div_pend.

Reset
REQ-027 RST=1 SHALL, next edge, set cnt=0, div_act=DIV_RST, div_pend=0, o_ld_pend=0, o_tick=0, o_clk_led=0, o_digit_sel=0, o_an=~1, o_frame=0, o_blank=0, frame counter=0.
REQ-028 RST SHALL dominate i_ce, i_div_ld and any terminal count in the same cycle.

Configuration
REQ-029 Macro LED_BLINK_EN defined: frame counter counts o_frame pulses; every BLINK_FRAMES frames o_blank toggles; i_blink_en=0 forces o_blank=0 and clears the frame counter.
REQ-030 LED_BLINK_EN undefined: no frame counter, o_blank tied 0, i_blink_en ignored; ports unchanged.

Structure
REQ-031 Package led_pkg SHALL hold default CW/NDIG/DIV_RST/BLINK_FRAMES constants and the anode-active-low polarity constant.
REQ-032 Sub-module led_tick_div SHALL contain cnt, div_act, div_pend and load logic, emitting o_tick/o_ld_pend; digit, frame and blink logic stay in led_scan_timer.

Verification (CW=4, NDIG=4, DIV_RST=3, BLINK_FRAMES=2)
REQ-033 Release RST, i_ce=1 -> o_tick first high 5th cycle after release, then every 4 cycles; o_clk_led period 8.
REQ-034 Continue -> o_an 1110,1101,1011,0111,1110 per tick; o_frame high with the 4th tick only.
REQ-035 i_ce alternating 1/0 -> tick period 8 cycles, no tick while i_ce=0.
REQ-036 Pulse i_div_ld with i_div=0 at cnt=1 -> o_ld_pend high until wrap, then o_tick every cycle; repeat with ld at cnt=3 -> o_ld_pend never asserts.
REQ-037 RST at cnt=2, digit=2 -> next cycle cnt=0, o_an=1110, o_clk_led=0, div_act=3.
REQ-038 LED_BLINK_EN, i_blink_en=1 -> o_blank toggles every 32 cycles; drop i_blink_en -> o_blank=0 next cycle.
